decode_stage_hz: RTL

- Parametrised successor to the Y86-64 pipeline decode stage.
- Owns the architectural register file, the D->E pipeline register and the pipeline hazard-control logic:
  - load/use stall
  - mispredicted-branch bubble
  - ret bubble
- Sits between the F/D pipeline register and execute; drives stall/bubble requests back to fetch and the D register.
- Outputs are registered: decode results appear on the E_* ports one cycle after D_* inputs are sampled.

---
 rtl/y86_pkg.sv | 25 ++
 rtl/regfile_2w.sv | 50 +++++
 rtl/decode_stage_hz.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and special register IDs.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'd0;
    localparam logic [3:0] I_NOP   = 4'd1;
    localparam logic [3:0] I_CMOV  = 4'd2;
    localparam logic [3:0] I_IRMOV = 4'd3;
    localparam logic [3:0] I_RMMOV = 4'd4;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_OPQ   = 4'd6;
    localparam logic [3:0] I_JXX   = 4'd7;
    localparam logic [3:0] I_CALL  = 4'd8;
    localparam logic [3:0] I_RET   = 4'd9;
    localparam logic [3:0] I_PUSH  = 4'd10;
    localparam logic [3:0] I_POP   = 4'd11;

    localparam logic [1:0] S_AOK = 2'd0;
    localparam logic [1:0] S_HLT = 2'd1;
    localparam logic [1:0] S_ADR = 2'd2;
    localparam logic [1:0] S_INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

endpackage

// File: rtl/regfile_2w.sv
// Architectural register file: two write ports (M wins on conflict), two read ports, one debug read.
module regfile_2w #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 15,
    parameter int unsigned RW    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_e,
    input  logic [RW-1:0]   wa_e,
    input  logic [XLEN-1:0] wd_e,
    input  logic            we_m,
    input  logic [RW-1:0]   wa_m,
    input  logic [XLEN-1:0] wd_m,
    input  logic [RW-1:0]   ra_a,
    output logic [XLEN-1:0] rd_a,
    input  logic [RW-1:0]   ra_b,
    output logic [XLEN-1:0] rd_b,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREGS];

    // Synchronous clear, then per-entry write with the M port taking priority.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREGS); i++) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (we_m && wa_m == RW'(i)) begin
                regs[i] <= wd_m;
            end else if (we_e && wa_e == RW'(i)) begin
                regs[i] <= wd_e;
            end
        end
    end

    // Combinational reads; addresses with no backing entry return zero.
    always_comb begin
        rd_a     = '0;
        rd_b     = '0;
        dbg_data = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (ra_a == RW'(i))     rd_a     = regs[i];
            if (ra_b == RW'(i))     rd_b     = regs[i];
            if (dbg_addr == RW'(i)) dbg_data = regs[i];
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// Pipeline decode stage: register decode and forwarding, hazard control, D->E register.
module decode_stage_hz #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 15,
    parameter int unsigned RW    = 4,
    parameter int unsigned RSP   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [RW-1:0]   D_rA,
    input  logic [RW-1:0]   D_rB,
    input  logic [XLEN-1:0] D_valC,
    input  logic [XLEN-1:0] D_valP,
    input  logic [RW-1:0]   e_dstE,
    input  logic [XLEN-1:0] e_valE,
    input  logic            e_Cnd,
    input  logic [3:0]      M_icode,
    input  logic [RW-1:0]   M_dstE,
    input  logic [RW-1:0]   M_dstM,
    input  logic [XLEN-1:0] M_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [1:0]      W_stat,
    input  logic [3:0]      W_icode,
    input  logic [RW-1:0]   W_dstE,
    input  logic [RW-1:0]   W_dstM,
    input  logic [XLEN-1:0] W_valE,
    input  logic [XLEN-1:0] W_valM,
    output logic [1:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [XLEN-1:0] E_valC,
    output logic [XLEN-1:0] E_valA,
    output logic [XLEN-1:0] E_valB,
    output logic [RW-1:0]   E_dstE,
    output logic [RW-1:0]   E_dstM,
    output logic [RW-1:0]   E_srcA,
    output logic [RW-1:0]   E_srcB,
    output logic            f_stall,
    output logic            d_stall,
    output logic            d_bubble,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    import y86_pkg::*;

    localparam logic [RW-1:0] R_NONE = {RW{1'b1}};
    localparam logic [RW-1:0] R_SP   = RW'(RSP);

    logic [RW-1:0]   d_srcA, d_srcB, d_dstE, d_dstM;
    logic [XLEN-1:0] rf_a, rf_b, d_valA, d_valB;
    logic            w_ok, load_use, mispredict, ret_pend;

    // W_icode carries no decision here; writes are gated by status alone.
    logic [3:0] w_icode_unused;
    assign w_icode_unused = W_icode;

    // A source is real only if it names a backed register other than RNONE.
    function automatic logic src_ok(input logic [RW-1:0] src);
        return (src != R_NONE) && ({1'b0, src} < (RW+1)'(NREGS));
    endfunction

    // Forwarding chain, youngest producer first, falling back to the regfile.
    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] src, input logic [XLEN-1:0] rf);
        if (!src_ok(src))        return '0;
        else if (src == e_dstE)  return e_valE;
        else if (src == M_dstM)  return m_valM;
        else if (src == M_dstE)  return M_valE;
        else if (src == W_dstM)  return W_valM;
        else if (src == W_dstE)  return W_valE;
        else                     return rf;
    endfunction

    assign w_ok = (W_stat == S_AOK);

    regfile_2w #(.XLEN(XLEN), .NREGS(NREGS), .RW(RW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_e     (w_ok && W_dstE != R_NONE),
        .wa_e     (W_dstE),
        .wd_e     (W_valE),
        .we_m     (w_ok && W_dstM != R_NONE),
        .wa_m     (W_dstM),
        .wd_m     (W_valM),
        .ra_a     (d_srcA),
        .rd_a     (rf_a),
        .ra_b     (d_srcB),
        .rd_b     (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Register-specifier decode by instruction class.
    always_comb begin
        d_srcA = R_NONE;
        d_srcB = R_NONE;
        d_dstE = R_NONE;
        d_dstM = R_NONE;
        case (D_icode)
            I_CMOV:  begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            I_IRMOV: begin d_srcB = D_rB; d_dstE = D_rB; end
            I_RMMOV: begin d_srcA = D_rA; d_srcB = D_rB; end
            I_MRMOV: begin d_srcB = D_rB; d_dstM = D_rA; end
            I_OPQ:   begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            I_CALL:  begin d_srcB = R_SP; d_dstE = R_SP; end
            I_RET:   begin d_srcA = R_SP; d_srcB = R_SP; d_dstE = R_SP; end
            I_PUSH:  begin d_srcA = D_rA; d_srcB = R_SP; d_dstE = R_SP; end
            I_POP:   begin d_srcA = R_SP; d_srcB = R_SP; d_dstE = R_SP; d_dstM = D_rA; end
            default: ;
        endcase
    end

    // Operand selection; call/jump carry the fall-through PC in valA.
    always_comb begin
        d_valA = fwd(d_srcA, rf_a);
        d_valB = fwd(d_srcB, rf_b);
        if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
    end

    // Hazard detection and stall/bubble requests.
    always_comb begin
        load_use   = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != R_NONE) &&
                     (E_dstM == d_srcA || E_dstM == d_srcB);
        mispredict = (E_icode == I_JXX) && !e_Cnd;
        ret_pend   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        f_stall    = load_use || ret_pend;
        d_stall    = load_use;
        d_bubble   = mispredict || (ret_pend && !load_use);
    end

    // D->E pipeline register; reset and bubbles load a NOP.
    always_ff @(posedge clk) begin
        if (!rst_n || mispredict || load_use) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'd0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= R_NONE;
            E_dstM  <= R_NONE;
            E_srcA  <= R_NONE;
            E_srcB  <= R_NONE;
        end else begin
            E_stat  <= D_stat;
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= d_valA;
            E_valB  <= d_valB;
            E_dstE  <= d_dstE;
            E_dstM  <= d_dstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

endmodule
